// File: rtl/imem_loader.sv
// imem_loader: Avalon-MM master that writes a word stream into the instruction RAM and freezes the core while loading.
// Latency: one RAM write in the same cycle each word is accepted; done one cycle after the last word,
//          or len+2 cycles after it when IMEM_LOADER_VERIFY_EN adds the read-back pass.
// Backpressure: in_ready only in WRITE and in_valid stalls simply hold; cmd_ready only in IDLE.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [ADDR_W:0]       cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata,
  output logic                  core_freeze,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     checksum
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef IMEM_LOADER_VERIFY_EN
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
`endif

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] sum_q;
  logic              err_q;

  logic              cmd_fire;
  logic              wr_fire;
  logic              last_word;
  logic [ADDR_W-1:0] base_fold;

`ifdef IMEM_LOADER_VERIFY_EN
  logic [ADDR_W:0]   rcnt_q;
  logic [DATA_W-1:0] rsum_q;
  logic              last_read;
  logic [DATA_W-1:0] rsum_final;
`else
  // Without the read-back pass the RAM read port has no consumer.
  logic              unused_readdata;
  assign unused_readdata = ^m_readdata;
`endif

  // RAM word address for (base + offset) wrapped into 0..DEPTH-1; base is kept below DEPTH
  // and offset below len <= DEPTH, so a single conditional subtract is enough.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W:0]   off);
    logic [ADDR_W+1:0] s;
    s = {2'b00, b} + {1'b0, off};
    if (s >= {1'b0, DEPTH_L}) begin
      s = s - {1'b0, DEPTH_L};
    end
    return s[ADDR_W-1:0];
  endfunction

  assign cmd_fire  = (state_q == S_IDLE) && cmd_valid;
  assign wr_fire   = (state_q == S_WRITE) && in_valid;
  assign last_word = (cnt_q == (len_q - CNT_ONE));

  // A base at or beyond DEPTH (only possible when DEPTH is not 2**ADDR_W) is folded back once.
  assign base_fold = ({1'b0, cmd_base} >= DEPTH_L) ? ADDR_W'({1'b0, cmd_base} - DEPTH_L) : cmd_base;

`ifdef IMEM_LOADER_VERIFY_EN
  assign last_read  = (rcnt_q == (len_q - CNT_ONE));
  assign rsum_final = rsum_q + m_readdata;
`endif

  // Handshake and status outputs decode straight from the state so reset takes effect at once.
  assign cmd_ready    = (state_q == S_IDLE);
  assign in_ready     = (state_q == S_WRITE);
  assign core_freeze  = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = err_q;
  assign checksum     = sum_q;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;
  assign m_writedata  = in_ready ? in_data : '0;

  // RAM command: writes follow in_valid combinationally, reads are issued every READ cycle.
  always_comb begin
    m_chipselect = wr_fire;
    m_write      = wr_fire;
    m_address    = '0;
    if (wr_fire) begin
      m_address = wrap_addr(base_q, cnt_q);
    end
`ifdef IMEM_LOADER_VERIFY_EN
    if (state_q == S_READ) begin
      m_chipselect = 1'b1;
      m_address    = wrap_addr(base_q, rcnt_q);
    end
`endif
  end

  // Main load sequencer: command capture, write counting, checksum and error tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            base_q <= base_fold;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            sum_q  <= '0;
            err_q  <= 1'b0;
            if (cmd_len == '0) begin
              state_q <= S_DONE;
            end else if (cmd_len > DEPTH_L) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (in_valid) begin
            cnt_q <= cnt_q + CNT_ONE;
            sum_q <= sum_q + in_data;
            if (last_word) begin
`ifdef IMEM_LOADER_VERIFY_EN
              state_q <= S_READ;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_VERIFY_EN
        S_READ: begin
          if (last_read) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rsum_final != sum_q) begin
            err_q <= 1'b1;
          end
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_VERIFY_EN
  // Read-back pass: the RAM returns data one cycle after the address, so the sum lags the
  // address counter by one and the final word is folded in by CHECK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q <= '0;
      rsum_q <= '0;
    end else if (cmd_fire) begin
      rcnt_q <= '0;
      rsum_q <= '0;
    end else if (state_q == S_READ) begin
      rcnt_q <= rcnt_q + CNT_ONE;
      if (rcnt_q != '0) begin
        rsum_q <= rsum_q + m_readdata;
      end
    end
  end
`endif

  // The RAM is only ever driven while the core is held frozen.
  a_write_frozen: assert property (@(posedge clk) disable iff (!reset_n) m_chipselect |-> core_freeze);
  // Handshakes are mutually exclusive.
  a_rdy_excl: assert property (@(posedge clk) disable iff (!reset_n) !(cmd_ready && in_ready));

endmodule
